cal_timer_datapath: RTL and testbench

//  Countdown-timer datapath driven by the cal_fsm control enables.

---
 rtl/cal_timer_datapath.sv | 152 +++++++++++++++
 tb/tb_cal_timer_datapath.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cal_timer_datapath.sv
// Countdown-timer datapath: BCD hh:mm:ss counters with set/run ticks, lap-freezable HH:MM display.
// Optional alarm output is enabled by defining CAL_TIMER_ALARM_EN.
module cal_timer_datapath #(
  parameter int TICK_DIV    = 40_000_000,
  parameter int MAX_HR      = 23,
  parameter int ALARM_TICKS = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       countuphr_enable,
  input  logic       countupmin_enable,
  input  logic       countdown_enable,
  input  logic       freeze,
  output logic [3:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic       zero,
  output logic       done,
  output logic       alarm
);

  localparam int         PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST  = PW'(TICK_DIV - 1);
  localparam logic [3:0] HR_MAX_T = 4'(MAX_HR / 10);
  localparam logic [3:0] HR_MAX_O = 4'(MAX_HR % 10);

  // {tens, ones} + 1 with wrap from {max_t, max_o} to 00
  function automatic logic [7:0] inc_bcd(input logic [7:0] v, input logic [3:0] max_t,
                                         input logic [3:0] max_o);
    if (v == {max_t, max_o})  return 8'h00;
    else if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    else                      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // {tens, ones} - 1 with 00 wrapping to {top_t, 9}
  function automatic logic [7:0] dec_bcd(input logic [7:0] v, input logic [3:0] top_t);
    if (v == 8'h00)           return {top_t, 4'd9};
    else if (v[3:0] == 4'd0)  return {v[7:4] - 4'd1, 4'd9};
    else                      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  logic [7:0]    hr_q, min_q, sec_q;
  logic [7:0]    hr_n, min_n, sec_n;
  logic [7:0]    disp_hr_q, disp_min_q;
  logic [PW-1:0] presc_q;
  logic          done_q, done_n;
  logic          any_en, run, tick, live_zero;

  assign any_en    = countuphr_enable | countupmin_enable | countdown_enable;
  assign tick      = run && (presc_q == LAST);
  assign live_zero = ({hr_q, min_q, sec_q} == 24'h0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              presc_q <= '0;
    else if (!run)             presc_q <= '0;
    else if (presc_q == LAST)  presc_q <= '0;
    else                       presc_q <= presc_q + 1'b1;
  end

  always_comb begin
    hr_n   = hr_q;
    min_n  = min_q;
    sec_n  = sec_q;
    done_n = 1'b0;
    if (tick) begin
      if (countuphr_enable) begin
        hr_n  = inc_bcd(hr_q, HR_MAX_T, HR_MAX_O);
        sec_n = 8'h00;
      end else if (countupmin_enable) begin
        min_n = inc_bcd(min_q, 4'd5, 4'd9);
        sec_n = 8'h00;
      end else if (countdown_enable && !live_zero) begin
        sec_n = dec_bcd(sec_q, 4'd5);
        if (sec_q == 8'h00) begin
          min_n = dec_bcd(min_q, 4'd5);
          // hr is nonzero whenever min and sec are both 00 on a nonzero count
          if (min_q == 8'h00) hr_n = dec_bcd(hr_q, 4'd0);
        end
        done_n = ({hr_n, min_n, sec_n} == 24'h0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hr_q   <= 8'h00;
      min_q  <= 8'h00;
      sec_q  <= 8'h00;
      done_q <= 1'b0;
    end else begin
      hr_q   <= hr_n;
      min_q  <= min_n;
      sec_q  <= sec_n;
      done_q <= done_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_hr_q  <= 8'h00;
      disp_min_q <= 8'h00;
    end else if (!freeze) begin
      disp_hr_q  <= hr_q;
      disp_min_q <= min_q;
    end
  end

  assign {hr_tens, hr_ones}   = disp_hr_q;
  assign {min_tens, min_ones} = disp_min_q;
  assign zero                 = live_zero;
  assign done                 = done_q;

`ifdef CAL_TIMER_ALARM_EN
  localparam int AW = $clog2(ALARM_TICKS + 1);

  logic          alarm_q;
  logic [AW-1:0] alarm_cnt_q;
  logic          hr_en_q, min_en_q, set_rise;

  // prescaler keeps ticking while the alarm is sounding so its duration is measured in ticks
  assign run      = any_en | alarm_q;
  assign set_rise = (countuphr_enable & ~hr_en_q) | (countupmin_enable & ~min_en_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alarm_q     <= 1'b0;
      alarm_cnt_q <= '0;
      hr_en_q     <= 1'b0;
      min_en_q    <= 1'b0;
    end else begin
      hr_en_q  <= countuphr_enable;
      min_en_q <= countupmin_enable;
      if (set_rise) begin
        alarm_q <= 1'b0;
      end else if (done_n) begin
        alarm_q     <= 1'b1;
        alarm_cnt_q <= '0;
      end else if (alarm_q && tick) begin
        if (alarm_cnt_q == AW'(ALARM_TICKS - 1)) alarm_q <= 1'b0;
        else                                     alarm_cnt_q <= alarm_cnt_q + 1'b1;
      end
    end
  end

  assign alarm = alarm_q;
`else
  assign run   = any_en;
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_cal_timer_datapath.sv
// Directed bench for cal_timer_datapath with TICK_DIV=4; alarm checks depend on CAL_TIMER_ALARM_EN.
module tb_cal_timer_datapath;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       hr_en = 1'b0, min_en = 1'b0, down_en = 1'b0, freeze = 1'b0;
  logic [3:0] hr_tens, hr_ones, min_tens, min_ones;
  logic       zero, done, alarm;

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  int done_base;

  cal_timer_datapath #(.TICK_DIV(TD), .MAX_HR(23), .ALARM_TICKS(5)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .countuphr_enable  (hr_en),
    .countupmin_enable (min_en),
    .countdown_enable  (down_en),
    .freeze            (freeze),
    .hr_tens           (hr_tens),
    .hr_ones           (hr_ones),
    .min_tens          (min_tens),
    .min_ones          (min_ones),
    .zero              (zero),
    .done              (done),
    .alarm             (alarm)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] disp();
    return {16'h0, hr_tens, hr_ones, min_tens, min_ones};
  endfunction

  // drivers: enables high for n ticks, then one idle clk so display equals live
  task automatic do_ticks(input logic h, input logic m, input logic d, input int n);
    hr_en = h; min_en = m; down_en = d;
    repeat (n * TD) @(posedge clk);
    @(negedge clk);
    hr_en = 1'b0; min_en = 1'b0; down_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    hr_en = 1'b0; min_en = 1'b0; down_en = 1'b0; freeze = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1;
    check("rst_disp", disp(), 32'h0000);
    check("rst_zero", zero, 1);
    check("rst_done", done, 0);
    check("rst_alarm", alarm, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // async reset mid-run at 01:02:03
    do_ticks(1, 0, 0, 1);
    do_ticks(0, 1, 0, 3);
    check("set_0103", disp(), 32'h0103);
    down_en = 1'b1;
    repeat (57 * TD) @(posedge clk);
    @(negedge clk);
    check("run_0102", disp(), 32'h0102);
    check("run_nz", zero, 0);
    reset_n = 1'b0;
    #1;
    check("arst_disp", disp(), 32'h0000);
    check("arst_zero", zero, 1);
    check("arst_done", done, 0);
    down_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // hour set wrap
    do_ticks(1, 0, 0, 23);
    check("hr_23", disp(), 32'h2300);
    check("hr_23_nz", zero, 0);
    do_ticks(1, 0, 0, 1);
    check("hr_wrap", disp(), 32'h0000);
    check("hr_wrap_z", zero, 1);
    do_ticks(1, 0, 0, 1);
    check("hr_01", disp(), 32'h0100);

    // countdown from 00:03:00 to zero
    do_reset();
    do_ticks(0, 1, 0, 3);
    check("min_03", disp(), 32'h0003);
    do_ticks(0, 0, 1, 1);
    check("cd_0259", disp(), 32'h0002);
    check("cd_nz", zero, 0);
    done_base = done_cnt;
    do_ticks(0, 0, 1, 178);
    check("cd_0001_nz", zero, 0);
    check("cd_0001_disp", disp(), 32'h0000);
    check("cd_no_early_done", done_cnt - done_base, 0);
    down_en = 1'b1;
    repeat (TD) @(posedge clk);
    @(negedge clk);
    check("cd_done_hi", done, 1);
    check("cd_zero", zero, 1);
    @(negedge clk);
    check("cd_done_lo", done, 0);
    down_en = 1'b0;
    @(negedge clk);
    check("cd_one_done", done_cnt - done_base, 1);
`ifndef CAL_TIMER_ALARM_EN
    check("alarm_tied", alarm, 0);
`endif
    do_ticks(0, 0, 1, 3);
    check("cd_hold_zero", zero, 1);
    check("cd_hold_disp", disp(), 32'h0000);
    check("cd_no_more_done", done_cnt - done_base, 1);

    // double borrow
    do_reset();
    do_ticks(1, 0, 0, 1);
    check("db_0100", disp(), 32'h0100);
    do_ticks(0, 0, 1, 1);
    check("db_0059", disp(), 32'h0059);
    check("db_nz", zero, 0);

    // freeze during countdown
    do_reset();
    do_ticks(0, 1, 0, 3);
    do_ticks(0, 0, 1, 30);
    check("fz_0230", disp(), 32'h0002);
    freeze = 1'b1;
    do_ticks(0, 0, 1, 40);
    check("fz_hold", disp(), 32'h0002);
    freeze = 1'b0;
    #1;
    check("fz_release_same", disp(), 32'h0002);
    @(negedge clk);
    check("fz_release_next", disp(), 32'h0001);
    do_ticks(0, 0, 1, 109);
    check("fz_0001_nz", zero, 0);
    do_ticks(0, 0, 1, 1);
    check("fz_live_0150", zero, 1);

`ifdef CAL_TIMER_ALARM_EN
    // alarm lasts five ticks
    do_reset();
    do_ticks(0, 1, 0, 1);
    do_ticks(0, 0, 1, 60);
    check("al_zero", zero, 1);
    check("al_rise", alarm, 1);
    repeat (18) @(posedge clk);
    @(negedge clk);
    check("al_last", alarm, 1);
    @(negedge clk);
    check("al_fall", alarm, 0);

    // set enable cancels alarm
    do_reset();
    do_ticks(0, 1, 0, 1);
    do_ticks(0, 0, 1, 60);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("al_2ticks", alarm, 1);
    min_en = 1'b1;
    @(negedge clk);
    check("al_cancel", alarm, 0);
    min_en = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
